// File: rtl/xbar_out_sched.sv
// Per-output-port crossbar scheduler: round-robin with packet locking,
// credit flow control and mux-aligned sideband. Option: XBAR_OUT_SCHED_TIMEOUT_EN.
module xbar_out_sched #(
   parameter int CREDITS = 4,
   parameter int MUX_LAT = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [21:0] i_req,
   input  logic [21:0] i_req_eop,
   input  logic        i_credit,
   output logic [21:0] o_grant,
   output logic [4:0]  o_sel,
   output logic        o_valid,
   output logic        o_eop,
   output logic [3:0]  o_credits
`ifdef XBAR_OUT_SCHED_TIMEOUT_EN
   ,
   output logic        o_timeout
`endif
);

   typedef enum logic {IDLE, LOCKED} state_t;

   localparam logic [3:0] CRED_MAX = 4'(CREDITS);

   state_t             state;
   state_t             state_nxt;
   logic [4:0]         rr_ptr;
   logic [4:0]         lock_idx;
   logic [4:0]         sel_q;
   logic [4:0]         win;
   logic [4:0]         idx;
   logic [5:0]         scan;
   logic               found;
   logic               grant;
   logic               gnt_eop;
   logic               can_send;
   logic [3:0]         credits;
   logic [MUX_LAT-1:0] v_pipe;
   logic [MUX_LAT-1:0] e_pipe;

`ifdef XBAR_OUT_SCHED_TIMEOUT_EN
   logic [7:0]         idle_cnt;
   logic               timeout;
`endif

   assign can_send  = (credits != 4'd0);
   assign gnt_eop   = grant & i_req_eop[idx];
   assign o_grant   = grant ? (22'd1 << idx) : 22'd0;
   assign o_sel     = idx;
   assign o_valid   = v_pipe[MUX_LAT-1];
   assign o_eop     = e_pipe[MUX_LAT-1];
   assign o_credits = credits;

   // first requester strictly after rr_ptr, wrapping 21 -> 0
   always_comb begin
      found = 1'b0;
      win   = 5'd0;
      scan  = 6'd0;
      for (int i = 1; i <= 22; i++) begin
         scan = {1'b0, rr_ptr} + 6'(i);
         if (scan >= 6'd22) scan = scan - 6'd22;
         if (!found && i_req[scan[4:0]]) begin
            found = 1'b1;
            win   = scan[4:0];
         end
      end
   end

   // next state, grant and select; sel holds its last value when idle
   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      idx       = sel_q;
`ifdef XBAR_OUT_SCHED_TIMEOUT_EN
      timeout   = 1'b0;
`endif
      unique case (state)
         IDLE: begin
            if (can_send && found) begin
               grant = 1'b1;
               idx   = win;
               if (!i_req_eop[win]) state_nxt = LOCKED;
            end
         end
         LOCKED: begin
            idx = lock_idx;
            if (can_send && i_req[lock_idx]) begin
               grant = 1'b1;
               if (i_req_eop[lock_idx]) state_nxt = IDLE;
            end
`ifdef XBAR_OUT_SCHED_TIMEOUT_EN
            else if (idle_cnt == 8'hFF) begin
               timeout   = 1'b1;
               state_nxt = IDLE;
            end
`endif
         end
      endcase
   end

   // state, pointers, credit counter and sideband delay line
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         rr_ptr   <= 5'd21;
         lock_idx <= 5'd0;
         sel_q    <= 5'd0;
         credits  <= CRED_MAX;
         v_pipe   <= '0;
         e_pipe   <= '0;
      end else begin
         state <= state_nxt;
         if (grant) begin
            rr_ptr   <= idx;
            lock_idx <= idx;
            sel_q    <= idx;
         end
`ifdef XBAR_OUT_SCHED_TIMEOUT_EN
         if (timeout) rr_ptr <= lock_idx;
`endif
         if (grant && !i_credit)
            credits <= credits - 4'd1;
         else if (!grant && i_credit && credits != CRED_MAX)
            credits <= credits + 4'd1;
         v_pipe[0] <= grant;
         e_pipe[0] <= gnt_eop;
         for (int i = 1; i < MUX_LAT; i++) begin
            v_pipe[i] <= v_pipe[i-1];
            e_pipe[i] <= e_pipe[i-1];
         end
      end
   end

`ifdef XBAR_OUT_SCHED_TIMEOUT_EN
   assign o_timeout = timeout;

   // cycles spent locked without a grant
   always_ff @(posedge clk) begin
      if (!rst_n)
         idle_cnt <= 8'd0;
      else if (state != LOCKED || grant || timeout)
         idle_cnt <= 8'd0;
      else
         idle_cnt <= idle_cnt + 8'd1;
   end
`endif

endmodule

// File: tb/tb_xbar_out_sched.sv
// Bench for xbar_out_sched: directed scenarios plus random traffic
// checked against a packet-level scheduler model.
module tb_xbar_out_sched;

   localparam int CREDITS = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [21:0] i_req = '0;
   logic [21:0] i_req_eop = '0;
   logic        i_credit = 1'b0;
   logic [21:0] o_grant;
   logic [4:0]  o_sel;
   logic        o_valid;
   logic        o_eop;
   logic [3:0]  o_credits;
`ifdef XBAR_OUT_SCHED_TIMEOUT_EN
   logic        o_timeout;
`endif

   xbar_out_sched #(.CREDITS(CREDITS), .MUX_LAT(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_req     (i_req),
      .i_req_eop (i_req_eop),
      .i_credit  (i_credit),
      .o_grant   (o_grant),
      .o_sel     (o_sel),
      .o_valid   (o_valid),
      .o_eop     (o_eop),
      .o_credits (o_credits)
`ifdef XBAR_OUT_SCHED_TIMEOUT_EN
      ,
      .o_timeout (o_timeout)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // model state
   bit          m_locked;
   int          m_owner;
   int          m_ptr;
   int          m_cred;
   int          m_sel;
   bit          hv[3];
   bit          he[3];
   // model expectations for the current cycle
   logic [21:0] e_grant;
   int          e_sel;
   int          e_cred;
   int          e_win;
   bit          e_valid;
   bit          e_eop;
   bit          e_feop;

   task automatic model_reset();
      m_locked = 0;
      m_owner  = 0;
      m_ptr    = 21;
      m_cred   = CREDITS;
      m_sel    = 0;
      for (int k = 0; k < 3; k++) begin
         hv[k] = 0;
         he[k] = 0;
      end
   endtask

   task automatic model_eval();
      e_win   = -1;
      e_sel   = m_locked ? m_owner : m_sel;
      e_cred  = m_cred;
      e_valid = hv[2];
      e_eop   = he[2];
      if (m_cred > 0) begin
         if (m_locked) begin
            if (i_req[m_owner]) e_win = m_owner;
         end else begin
            for (int k = 1; k <= 22 && e_win < 0; k++)
               if (i_req[(m_ptr + k) % 22]) e_win = (m_ptr + k) % 22;
         end
      end
      e_grant = '0;
      e_feop  = 0;
      if (e_win >= 0) begin
         e_grant[e_win] = 1'b1;
         e_sel  = e_win;
         e_feop = i_req_eop[e_win];
      end
   endtask

   task automatic model_commit();
      bit g;
      g = (e_win >= 0);
      hv[2] = hv[1]; hv[1] = hv[0]; hv[0] = g;
      he[2] = he[1]; he[1] = he[0]; he[0] = g && e_feop;
      if (g && !i_credit) m_cred--;
      else if (!g && i_credit && m_cred < CREDITS) m_cred++;
      if (g) begin
         m_ptr    = e_win;
         m_sel    = e_win;
         m_owner  = e_win;
         m_locked = !e_feop;
      end
   endtask

   task automatic step_pre(input logic [21:0] req, input logic [21:0] eop,
                           input logic cr);
      i_req     = req;
      i_req_eop = eop;
      i_credit  = cr;
      @(negedge clk);
      model_eval();
   endtask

   task automatic step_post();
      @(posedge clk);
      model_commit();
      #1;
   endtask

   task automatic do_reset();
      i_req = '0; i_req_eop = '0; i_credit = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      step_pre('0, '0, 1'b0);
      checks++;
      if ({o_grant, o_sel, o_valid, o_eop, o_credits} !==
          {22'd0, 5'd0, 1'b0, 1'b0, 4'(CREDITS)}) begin
         errors++;
         $display("FAIL reset: grant=%h sel=%0d v=%b e=%b cr=%0d required 0/0/0/0/%0d",
                  o_grant, o_sel, o_valid, o_eop, o_credits, CREDITS);
      end
      step_post();
   endtask

   task automatic test_single();
      do_reset();
      for (int c = 0; c < 5; c++) begin
         step_pre((c == 0) ? 22'h000001 : 22'h0, '1, 1'b0);
         checks++;
         if ({o_grant, o_sel, o_valid, o_eop, o_credits} !==
             {e_grant, 5'(e_sel), e_valid, e_eop, 4'(e_cred)}) begin
            errors++;
            $display("FAIL single c%0d: g=%h s=%0d v=%b e=%b cr=%0d required g=%h s=%0d v=%b e=%b cr=%0d",
                     c, o_grant, o_sel, o_valid, o_eop, o_credits,
                     e_grant, e_sel, e_valid, e_eop, e_cred);
         end
         checks++;
         if (c == 0 && (o_grant !== 22'h1 || o_sel !== 5'd0)) begin
            errors++;
            $display("FAIL single grant: g=%h s=%0d required 000001/0", o_grant, o_sel);
         end else if (c > 0 && ({o_valid, o_eop} !== {c == 3, c == 3} ||
                                o_credits !== 4'd3)) begin
            errors++;
            $display("FAIL single side c%0d: v=%b e=%b cr=%0d required v=e=%b cr=3",
                     c, o_valid, o_eop, o_credits, c == 3);
         end
         step_post();
      end
   endtask

   task automatic test_rr_sweep();
      logic [21:0] exp_g;
      do_reset();
      for (int c = 0; c < 23; c++) begin
         step_pre('1, '1, c != 0);
         exp_g = 22'd1 << (c % 22);
         checks++;
         if ({o_grant, o_sel, o_valid, o_eop, o_credits} !==
             {e_grant, 5'(e_sel), e_valid, e_eop, 4'(e_cred)}) begin
            errors++;
            $display("FAIL rr model c%0d: g=%h s=%0d cr=%0d required g=%h s=%0d cr=%0d",
                     c, o_grant, o_sel, o_credits, e_grant, e_sel, e_cred);
         end
         checks++;
         if (o_grant !== exp_g || o_sel !== 5'(c % 22) ||
             o_credits !== ((c == 0) ? 4'd4 : 4'd3)) begin
            errors++;
            $display("FAIL rr seq c%0d: g=%h s=%0d cr=%0d required g=%h s=%0d",
                     c, o_grant, o_sel, o_credits, exp_g, c % 22);
         end
         step_post();
      end
   endtask

   task automatic test_lock();
      logic [21:0] req;
      logic [21:0] eop;
      do_reset();
      for (int c = 0; c < 8; c++) begin
         req = 22'h0;
         eop = 22'h0;
         req[6] = 1'b1;
         eop[6] = 1'b1;
         req[5] = (c < 4);
         eop[5] = (c == 3);
         step_pre(req, eop, 1'b1);
         checks++;
         if ({o_grant, o_sel, o_valid, o_eop, o_credits} !==
             {e_grant, 5'(e_sel), e_valid, e_eop, 4'(e_cred)}) begin
            errors++;
            $display("FAIL lock model c%0d: g=%h s=%0d required g=%h s=%0d",
                     c, o_grant, o_sel, e_grant, e_sel);
         end
         checks++;
         if (o_sel !== ((c < 4) ? 5'd5 : 5'd6) || o_grant === 22'h0) begin
            errors++;
            $display("FAIL lock seq c%0d: s=%0d g=%h required s=%0d",
                     c, o_sel, o_grant, (c < 4) ? 5 : 6);
         end
         step_post();
      end
   endtask

   task automatic test_credit_exhaust();
      int grants = 0;
      do_reset();
      for (int c = 0; c < 9; c++) begin
         step_pre(22'h000080, '1, c == 6);
         checks++;
         if ({o_grant, o_sel, o_valid, o_eop, o_credits} !==
             {e_grant, 5'(e_sel), e_valid, e_eop, 4'(e_cred)}) begin
            errors++;
            $display("FAIL credit model c%0d: g=%h cr=%0d required g=%h cr=%0d",
                     c, o_grant, o_credits, e_grant, e_cred);
         end
         checks++;
         if ((o_grant != 22'h0) !== (c < 4 || c == 7)) begin
            errors++;
            $display("FAIL credit gate c%0d: g=%h required grant=%b",
                     c, o_grant, c < 4 || c == 7);
         end
         if (o_grant != 22'h0) grants++;
         step_post();
      end
      checks++;
      if (grants != 5) begin
         errors++;
         $display("FAIL credit count: grants=%0d required 5", grants);
      end
   endtask

   task automatic test_credit_sat();
      int exp_c[7] = '{4, 3, 2, 2, 3, 4, 4};
      do_reset();
      for (int c = 0; c < 7; c++) begin
         step_pre((c < 3) ? 22'h000008 : 22'h0, '1, c >= 2);
         checks++;
         if (o_credits !== 4'(exp_c[c]) || o_credits !== 4'(e_cred)) begin
            errors++;
            $display("FAIL credit sat c%0d: cr=%0d required %0d",
                     c, o_credits, exp_c[c]);
         end
         step_post();
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int c = 0; c < 2; c++) begin
         step_pre(22'h000200, '0, 1'b0);
         checks++;
         if (o_grant !== e_grant || o_grant !== 22'h000200) begin
            errors++;
            $display("FAIL rstmid lock c%0d: g=%h required 000200", c, o_grant);
         end
         step_post();
      end
      i_req = '0; i_req_eop = '0; i_credit = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      step_pre(22'h000208, '1, 1'b0);
      checks++;
      if ({o_valid, o_credits, o_grant} !== {1'b0, 4'd4, 22'h000008} ||
          o_grant !== e_grant) begin
         errors++;
         $display("FAIL rstmid: v=%b cr=%0d g=%h required v=0 cr=4 g=000008",
                  o_valid, o_credits, o_grant);
      end
      step_post();
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         step_pre(22'($urandom & $urandom), 22'($urandom), 1'($urandom_range(0, 1)));
         checks++;
         if ({o_grant, o_sel, o_valid, o_eop, o_credits} !==
             {e_grant, 5'(e_sel), e_valid, e_eop, 4'(e_cred)}) begin
            errors++;
            $display("FAIL random c%0d: g=%h s=%0d v=%b e=%b cr=%0d required g=%h s=%0d v=%b e=%b cr=%0d",
                     c, o_grant, o_sel, o_valid, o_eop, o_credits,
                     e_grant, e_sel, e_valid, e_eop, e_cred);
         end
         step_post();
      end
   endtask

`ifdef XBAR_OUT_SCHED_TIMEOUT_EN
   task automatic test_timeout();
      bit seen = 0;
      do_reset();
      step_pre(22'h000004, '0, 1'b0);
      step_post();
      i_req = 22'h000010; i_req_eop = '1;
      for (int n = 0; n < 300 && !seen; n++) begin
         @(negedge clk);
         if (o_timeout) seen = 1;
         @(posedge clk);
         #1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL timeout: no pulse within 300 cycles");
      end
      @(negedge clk);
      checks++;
      if (o_grant !== 22'h000010 || o_timeout !== 1'b0) begin
         errors++;
         $display("FAIL timeout regrant: g=%h to=%b required 000010/0",
                  o_grant, o_timeout);
      end
      @(posedge clk);
      #1;
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_rr_sweep();
      test_lock();
      test_credit_exhaust();
      test_credit_sat();
      test_reset_mid();
      test_random();
`ifdef XBAR_OUT_SCHED_TIMEOUT_EN
      test_timeout();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
